zorro2_autoconfig_master: RTL
=============================

Name: zorro2_autoconfig_master

Overview:
- Zorro II bus initiator that runs the AutoConfig sequence from the host side, for the card's bring-up and bench fixture builds.
- Reads each unconfigured board's config nibbles in $E80000 and allocates a 1MB-granular block in the $200000-$9FFFFF window.
- For each board it then writes either the base address ($E80048) or shut-up ($E8004C), and repeats until no board responds.
- Drives ASn/UDSn/RWn/ADDR/DBUS and samples DTACKn/BERRn using the same 7MHz CLK as the memory controller.

Parameters:
- MAX_BOARDS, 8: maximum boards processed per run before forcing DONE.
- TIMEOUT_CYCLES, 64: CLK cycles to wait for DTACKn before declaring no board present.

Ports:
- CLK  in  1  7MHz clock (C1n XNOR C3n); all logic on posedge.
- RESETn  in  1  asynchronous, active-low reset.
- start  in  1  single-cycle pulse that begins a run; ignored while busy.
- busy  out  1  high from the cycle after start until DONE.
- done  out  1  one-cycle pulse at the end of a run.
- ADDR  out  23  bus address [23:1].
- ASn, UDSn, LDSn, RWn  out  1 each  bus strobes. LDSn is held high at all times.
- DBUS_OUT  out  4  write nibble, placed on D[15:12].
- DBUS_OE  out  1  enables the external DBUS_OUT buffer.
- DBUS_IN  in  4  D[15:12] read data.
- DTACKn, BERRn  in  1 each  target acknowledge and bus error.
- cfg_valid  out  1  one-cycle strobe, one per board processed.
- cfg_base  out  4  ADDR[23:20] assigned to the board; 0 when shut up.
- cfg_size  out  4  board size in MB (1, 2, 4 or 8); 0 when unsupported.
- cfg_shutup  out  1  board was told to shut up.
- board_count  out  4  boards processed in the current run.
- mem_top  out  4  next free 1MB index; starts at 2, maximum $A.

Behaviour:
- Reset values:
  - ASn, UDSn, LDSn, RWn = 1; DBUS_OE = 0; ADDR = 0; DBUS_OUT = 0.
  - busy, done, cfg_valid, cfg_shutup = 0; cfg_base, cfg_size, board_count = 0; mem_top = 2.
- Reset asserted mid-cycle releases every strobe immediately (asynchronous); the FSM returns to IDLE.
- Bus access sub-sequence, used by every read and write:
  - A0: drive ADDR and RWn; on writes also DBUS_OUT with DBUS_OE = 1.
  - A1: ASn = 0, UDSn = 0. The wait counter clears.
  - AW: each posedge with DTACKn == 0 latches DBUS_IN and moves to A_END. BERRn == 0, or the counter reaching TIMEOUT_CYCLES, sets a fault and moves to A_END.
  - A_END: ASn = UDSn = 1. The following cycle sets RWn = 1 and DBUS_OE = 0.
  - Minimum access length is 4 CLK.
- FSM states: IDLE -> RD_TYPE ($E80000) -> RD_SIZE ($E80002) -> [ID reads] -> ALLOC -> WR_BASE or WR_SHUTUP -> REPORT -> NEXT -> back to RD_TYPE, or DONE -> IDLE.
- start resets mem_top to 2 and board_count to 0.
- Any fault in RD_TYPE means no board is present: go to DONE with no strobe.
- A fault in any other state: treat the board as shut up, report it, then go to DONE.
- The $00 and $02 nibbles are read uninverted.
- Type check: Zorro II requires nibble[3:2] == 2'b11; any other type goes to WR_SHUTUP.
- Size code from $02 nibble[2:0]:
  - 000 = 8MB, 111 = 4MB, 110 = 2MB, 101 = 1MB.
  - Any other code gives size 0 and goes to WR_SHUTUP.
- ALLOC, with M = mem_top:
  - 8MB: only when M == 2; base = 2.
  - 4MB / 2MB: base = M rounded up to even.
  - 1MB: base = M.
  - Fit check: base + size <= $A, otherwise WR_SHUTUP.
  - Sums use 5-bit arithmetic, so there is no wrap.
- WR_BASE: write base to byte $E80048, i.e. ADDR[8:1] = 8'h24, ADDR[23:16] = $E8, DBUS_OUT = base. Then mem_top = base + size.
- WR_SHUTUP: write 0 to byte $E8004C, i.e. ADDR[8:1] = 8'h26. mem_top is unchanged.
- REPORT: one-cycle cfg_valid with cfg_base, cfg_size and cfg_shutup; board_count increments.
- NEXT: if board_count == MAX_BOARDS go to DONE, otherwise RD_TYPE. The next board's CFGINn is released by the previous board's CFGOUTn at ASn rise.
- Multi-offer boards are handled naturally: a shut-up board may re-offer a smaller size and is processed again as a new board.

Optional Feature:
- Macro CFG_ID_READ_EN.
- With it defined, RD_SIZE is followed by six reads: product at ADDR[8:1] = 02..03 and manufacturer at 08..0B.
  - Each nibble is inverted on capture.
  - The results are exposed as cfg_prod[7:0] and cfg_mfg[15:0], valid with cfg_valid.
- Without it, those ports do not exist and no ID reads occur.

Test Plan:
- Model board offers type $E, size nibble $0 (8MB), then stops responding -> write $2 to $E80048; cfg_base = 2, cfg_size = 8, mem_top = $A; board_count = 1; done.
- Model 2MB board then 4MB board -> bases 2 then 4; mem_top = 8; two cfg_valid strobes.
- 4MB board then 8MB board -> base 2; then shut-up write to $E8004C with cfg_shutup = 1; mem_top stays 6.
- Empty bus: DTACKn held high -> timeout after 64 cycles; done with board_count = 0 and no cfg_valid; all strobes high.
- 1MB, then 4MB -> bases 2 and 4 (rounded up to even); mem_top = 8.
- RESETn pulsed low while ASn = 0 in AW -> ASn, UDSn, DBUS_OE released in the same cycle; busy = 0; mem_top = 2.

Source files
------------

// File: rtl/zorro2_autoconfig_master.sv
// Zorro II AutoConfig initiator.
// Walks the AutoConfig chain from the host side. For each board it reads the
// type and size nibbles at $E80000/$E80002 and allocates a 1MB-granular block
// inside $200000-$9FFFFF. It then writes the base nibble to $E80048, or writes
// shut-up to $E8004C, and repeats until a read of $E80000 goes unanswered.
// Optional build macro CFG_ID_READ_EN: adds six ID nibble reads (product and
// manufacturer) after the size read and exposes them on cfg_prod/cfg_mfg.
module zorro2_autoconfig_master #(
  parameter int MAX_BOARDS     = 8,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic        CLK,
  input  logic        RESETn,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic [23:1] ADDR,
  output logic        ASn,
  output logic        UDSn,
  output logic        LDSn,
  output logic        RWn,
  output logic [3:0]  DBUS_OUT,
  output logic        DBUS_OE,
  input  logic [3:0]  DBUS_IN,
  input  logic        DTACKn,
  input  logic        BERRn,
  output logic        cfg_valid,
  output logic [3:0]  cfg_base,
  output logic [3:0]  cfg_size,
  output logic        cfg_shutup,
`ifdef CFG_ID_READ_EN
  output logic [7:0]  cfg_prod,
  output logic [15:0] cfg_mfg,
`endif
  output logic [3:0]  board_count,
  output logic [3:0]  mem_top
);

  localparam int WCNT_W = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [3:0] {
    S_IDLE, S_RD_TYPE, S_RD_SIZE, S_RD_ID, S_ALLOC,
    S_WR_BASE, S_WR_SHUTUP, S_REPORT, S_NEXT, S_DONE
  } state_t;

  // Bus phase: B_IDLE is the setup cycle before A0 is put on the bus.
  typedef enum logic [2:0] {B_IDLE, B_A0, B_A1, B_AW, B_END} bph_t;

  // Size code from the $02 nibble to size in MB; 0 means unsupported.
  function automatic logic [3:0] decode_size(input logic [2:0] code);
    case (code)
      3'b000:  return 4'd8;
      3'b111:  return 4'd4;
      3'b110:  return 4'd2;
      3'b101:  return 4'd1;
      default: return 4'd0;
    endcase
  endfunction

  // 2MB and 4MB blocks are aligned to an even 1MB index.
  function automatic logic [4:0] round_up_even(input logic [4:0] m);
    return (m + 5'd1) & 5'b11110;
  endfunction

`ifdef CFG_ID_READ_EN
  // ADDR[8:1] offsets of the product (2) and manufacturer (4) nibbles.
  function automatic logic [7:0] id_offset(input logic [2:0] idx);
    case (idx)
      3'd0:    return 8'h02;
      3'd1:    return 8'h03;
      3'd2:    return 8'h08;
      3'd3:    return 8'h09;
      3'd4:    return 8'h0A;
      default: return 8'h0B;
    endcase
  endfunction
`endif

  state_t        state_q, state_d;
  bph_t          bph_q, bph_d;
  logic [WCNT_W-1:0] wcnt_q, wcnt_d;
  logic [3:0]    rdat_q, rdat_d;
  logic          fault_q, fault_d;
  logic          abort_q, abort_d;
  logic          zii_q, zii_d;
  logic [3:0]    size_q, size_d;
  logic [3:0]    base_q, base_d;
  logic [23:1]   addr_q, addr_d;
  logic          asn_q, asn_d;
  logic          udsn_q, udsn_d;
  logic          rwn_q, rwn_d;
  logic [3:0]    dout_q, dout_d;
  logic          doe_q, doe_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          cfg_valid_q, cfg_valid_d;
  logic [3:0]    cfg_base_q, cfg_base_d;
  logic [3:0]    cfg_size_q, cfg_size_d;
  logic          cfg_shutup_q, cfg_shutup_d;
  logic [3:0]    board_count_q, board_count_d;
  logic [3:0]    mem_top_q, mem_top_d;
`ifdef CFG_ID_READ_EN
  logic [2:0]    id_idx_q, id_idx_d;
  logic [7:0]    prod_sh_q, prod_sh_d;
  logic [15:0]   mfg_sh_q, mfg_sh_d;
  logic [7:0]    cfg_prod_q, cfg_prod_d;
  logic [15:0]   cfg_mfg_q, cfg_mfg_d;
`endif

  logic          bus_state;
  logic          acc_end;
  logic [23:1]   acc_addr;
  logic          acc_wr;
  logic [3:0]    acc_data;
  logic [4:0]    m5;
  logic [4:0]    alloc_base;
  logic [4:0]    alloc_end;
  logic          alloc_ok;
  logic          alloc_fit;

  // Address, direction and write nibble of the access owned by the current state.
  always_comb begin
    acc_addr  = {8'hE8, 7'h00, 8'h00};
    acc_wr    = 1'b0;
    acc_data  = 4'h0;
    bus_state = 1'b0;
    case (state_q)
      S_RD_TYPE:   bus_state = 1'b1;
      S_RD_SIZE: begin
        bus_state = 1'b1;
        acc_addr  = {8'hE8, 7'h00, 8'h01};
      end
`ifdef CFG_ID_READ_EN
      S_RD_ID: begin
        bus_state = 1'b1;
        acc_addr  = {8'hE8, 7'h00, id_offset(id_idx_q)};
      end
`endif
      S_WR_BASE: begin
        bus_state = 1'b1;
        acc_addr  = {8'hE8, 7'h00, 8'h24};
        acc_wr    = 1'b1;
        acc_data  = base_q;
      end
      S_WR_SHUTUP: begin
        bus_state = 1'b1;
        acc_addr  = {8'hE8, 7'h00, 8'h26};
        acc_wr    = 1'b1;
      end
      default: ;
    endcase
    acc_end = bus_state && (bph_q == B_END);
  end

  // Allocation of the next block from mem_top; sums are 5 bits so they never wrap.
  always_comb begin
    m5         = {1'b0, mem_top_q};
    alloc_base = m5;
    alloc_ok   = 1'b0;
    case (size_q)
      4'd8: begin
        alloc_base = 5'd2;
        alloc_ok   = (mem_top_q == 4'd2);
      end
      4'd4, 4'd2: begin
        alloc_base = round_up_even(m5);
        alloc_ok   = 1'b1;
      end
      4'd1: begin
        alloc_base = m5;
        alloc_ok   = 1'b1;
      end
      default: ;
    endcase
    alloc_end = alloc_base + {1'b0, size_q};
    alloc_fit = alloc_ok && zii_q && (alloc_end <= 5'd10);
  end

  // Next-state logic for the bus sequencer and the AutoConfig walk.
  always_comb begin
    state_d       = state_q;
    bph_d         = bph_q;
    wcnt_d        = wcnt_q;
    rdat_d        = rdat_q;
    fault_d       = fault_q;
    abort_d       = abort_q;
    zii_d         = zii_q;
    size_d        = size_q;
    base_d        = base_q;
    addr_d        = addr_q;
    asn_d         = asn_q;
    udsn_d        = udsn_q;
    rwn_d         = rwn_q;
    dout_d        = dout_q;
    doe_d         = doe_q;
    busy_d        = busy_q;
    done_d        = done_q;
    cfg_valid_d   = cfg_valid_q;
    cfg_base_d    = cfg_base_q;
    cfg_size_d    = cfg_size_q;
    cfg_shutup_d  = cfg_shutup_q;
    board_count_d = board_count_q;
    mem_top_d     = mem_top_q;
`ifdef CFG_ID_READ_EN
    id_idx_d      = id_idx_q;
    prod_sh_d     = prod_sh_q;
    mfg_sh_d      = mfg_sh_q;
    cfg_prod_d    = cfg_prod_q;
    cfg_mfg_d     = cfg_mfg_q;
`endif

    if (bus_state) begin
      case (bph_q)
        B_IDLE: begin
          addr_d = acc_addr;
          rwn_d  = ~acc_wr;
          if (acc_wr) begin
            dout_d = acc_data;
            doe_d  = 1'b1;
          end
          bph_d = B_A0;
        end
        B_A0: begin
          asn_d  = 1'b0;
          udsn_d = 1'b0;
          wcnt_d = '0;
          bph_d  = B_A1;
        end
        B_A1: bph_d = B_AW;
        B_AW: begin
          if (!DTACKn) begin
            rdat_d  = DBUS_IN;
            fault_d = 1'b0;
            asn_d   = 1'b1;
            udsn_d  = 1'b1;
            bph_d   = B_END;
          end else if (!BERRn || (wcnt_q == WCNT_W'(TIMEOUT_CYCLES - 1))) begin
            fault_d = 1'b1;
            asn_d   = 1'b1;
            udsn_d  = 1'b1;
            bph_d   = B_END;
          end else begin
            wcnt_d = wcnt_q + 1'b1;
          end
        end
        default: begin
          rwn_d = 1'b1;
          doe_d = 1'b0;
          bph_d = B_IDLE;
        end
      endcase
    end

    // A fault after the type read means the board is reported as shut up and the run ends.
    if (acc_end && fault_q && (state_q != S_RD_TYPE)) begin
      cfg_valid_d   = 1'b1;
      cfg_base_d    = 4'd0;
      cfg_size_d    = size_q;
      cfg_shutup_d  = 1'b1;
      board_count_d = board_count_q + 1'b1;
      abort_d       = 1'b1;
`ifdef CFG_ID_READ_EN
      cfg_prod_d    = prod_sh_q;
      cfg_mfg_d     = mfg_sh_q;
`endif
      state_d       = S_REPORT;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            busy_d        = 1'b1;
            mem_top_d     = 4'd2;
            board_count_d = 4'd0;
            abort_d       = 1'b0;
            state_d       = S_RD_TYPE;
          end
        end
        S_RD_TYPE: begin
          if (acc_end) begin
            if (fault_q) begin
              busy_d  = 1'b0;
              done_d  = 1'b1;
              state_d = S_DONE;
            end else begin
              zii_d   = (rdat_q[3:2] == 2'b11);
              size_d  = 4'd0;
              state_d = S_RD_SIZE;
            end
          end
        end
        S_RD_SIZE: begin
          if (acc_end) begin
            size_d = decode_size(rdat_q[2:0]);
`ifdef CFG_ID_READ_EN
            id_idx_d = 3'd0;
            state_d  = S_RD_ID;
`else
            state_d  = S_ALLOC;
`endif
          end
        end
`ifdef CFG_ID_READ_EN
        S_RD_ID: begin
          if (acc_end) begin
            if (id_idx_q < 3'd2) prod_sh_d = {prod_sh_q[3:0], ~rdat_q};
            else                 mfg_sh_d  = {mfg_sh_q[11:0], ~rdat_q};
            if (id_idx_q == 3'd5) state_d = S_ALLOC;
            else                  id_idx_d = id_idx_q + 1'b1;
          end
        end
`endif
        S_ALLOC: begin
          if (alloc_fit) begin
            base_d  = alloc_base[3:0];
            state_d = S_WR_BASE;
          end else begin
            base_d  = 4'd0;
            state_d = S_WR_SHUTUP;
          end
        end
        S_WR_BASE, S_WR_SHUTUP: begin
          if (acc_end) begin
            cfg_valid_d   = 1'b1;
            cfg_size_d    = size_q;
            board_count_d = board_count_q + 1'b1;
`ifdef CFG_ID_READ_EN
            cfg_prod_d    = prod_sh_q;
            cfg_mfg_d     = mfg_sh_q;
`endif
            if (state_q == S_WR_BASE) begin
              mem_top_d    = base_q + size_q;
              cfg_base_d   = base_q;
              cfg_shutup_d = 1'b0;
            end else begin
              cfg_base_d   = 4'd0;
              cfg_shutup_d = 1'b1;
            end
            state_d = S_REPORT;
          end
        end
        S_REPORT: begin
          cfg_valid_d = 1'b0;
          state_d     = S_NEXT;
        end
        S_NEXT: begin
          if (abort_q || (board_count_q == 4'(MAX_BOARDS))) begin
            busy_d  = 1'b0;
            done_d  = 1'b1;
            state_d = S_DONE;
          end else begin
            state_d = S_RD_TYPE;
          end
        end
        S_DONE: begin
          done_d  = 1'b0;
          state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // State and registered outputs; reset releases every strobe at once.
  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      state_q       <= S_IDLE;
      bph_q         <= B_IDLE;
      wcnt_q        <= '0;
      rdat_q        <= 4'd0;
      fault_q       <= 1'b0;
      abort_q       <= 1'b0;
      zii_q         <= 1'b0;
      size_q        <= 4'd0;
      base_q        <= 4'd0;
      addr_q        <= '0;
      asn_q         <= 1'b1;
      udsn_q        <= 1'b1;
      rwn_q         <= 1'b1;
      dout_q        <= 4'd0;
      doe_q         <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      cfg_valid_q   <= 1'b0;
      cfg_base_q    <= 4'd0;
      cfg_size_q    <= 4'd0;
      cfg_shutup_q  <= 1'b0;
      board_count_q <= 4'd0;
      mem_top_q     <= 4'd2;
`ifdef CFG_ID_READ_EN
      id_idx_q      <= 3'd0;
      prod_sh_q     <= 8'd0;
      mfg_sh_q      <= 16'd0;
      cfg_prod_q    <= 8'd0;
      cfg_mfg_q     <= 16'd0;
`endif
    end else begin
      state_q       <= state_d;
      bph_q         <= bph_d;
      wcnt_q        <= wcnt_d;
      rdat_q        <= rdat_d;
      fault_q       <= fault_d;
      abort_q       <= abort_d;
      zii_q         <= zii_d;
      size_q        <= size_d;
      base_q        <= base_d;
      addr_q        <= addr_d;
      asn_q         <= asn_d;
      udsn_q        <= udsn_d;
      rwn_q         <= rwn_d;
      dout_q        <= dout_d;
      doe_q         <= doe_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      cfg_valid_q   <= cfg_valid_d;
      cfg_base_q    <= cfg_base_d;
      cfg_size_q    <= cfg_size_d;
      cfg_shutup_q  <= cfg_shutup_d;
      board_count_q <= board_count_d;
      mem_top_q     <= mem_top_d;
`ifdef CFG_ID_READ_EN
      id_idx_q      <= id_idx_d;
      prod_sh_q     <= prod_sh_d;
      mfg_sh_q      <= mfg_sh_d;
      cfg_prod_q    <= cfg_prod_d;
      cfg_mfg_q     <= cfg_mfg_d;
`endif
    end
  end

  assign ADDR        = addr_q;
  assign ASn         = asn_q;
  assign UDSn        = udsn_q;
  assign LDSn        = 1'b1;
  assign RWn         = rwn_q;
  assign DBUS_OUT    = dout_q;
  assign DBUS_OE     = doe_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign cfg_valid   = cfg_valid_q;
  assign cfg_base    = cfg_base_q;
  assign cfg_size    = cfg_size_q;
  assign cfg_shutup  = cfg_shutup_q;
  assign board_count = board_count_q;
  assign mem_top     = mem_top_q;
`ifdef CFG_ID_READ_EN
  assign cfg_prod    = cfg_prod_q;
  assign cfg_mfg     = cfg_mfg_q;
`endif

endmodule
